// File: rtl/rv_pkg.sv
// Shared RV32 core definitions: data width, canonical NOP and the fetch
// stage's {pc, data} entry type.
package rv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush. DEPTH must be a power of two
// so the read/write pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32 instruction fetch: sequential PC generation, credit-limited imem
// requests, in-order response buffering and redirect flush with drop count.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [CW-1:0]   occupancy;
    logic [CW:0]     credit_used;
    logic            ififo_empty, ififo_full;
    fetch_entry_t    head_entry, push_entry;
    logic            accept, rsp_keep, inst_pop;

    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   pcfifo_count;
    logic            pcfifo_full, pcfifo_empty;
    logic            unused_status;

    // Buffered plus in-flight entries; a same-cycle pop earns no credit.
    assign credit_used    = {1'b0, occupancy} + {1'b0, outstanding_q};
    assign imem_req_valid = rst_n && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    assign rsp_keep   = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign push_entry = '{pc: rsp_pc, data: imem_rsp_data};

    assign inst_valid = !ififo_empty && !redirect_valid;
    assign inst_data  = ififo_empty ? INST_NOP : head_entry.data;
    assign inst_pc    = head_entry.pc;
    assign inst_pop   = inst_valid && inst_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
        drop_d        = drop_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            // Pending drops are a subset of outstanding, so every response
            // still due after this cycle is stale.
            drop_d     = outstanding_q - CW'(imem_rsp_valid);
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
            if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rsp_keep),
        .push_data_i (push_entry),
        .pop_i       (inst_pop),
        .flush_i     (redirect_valid),
        .head_o      (head_entry),
        .count_o     (occupancy),
        .full_o      (ififo_full),
        .empty_o     (ififo_empty)
    );

    // Never flushed: stale responses still pop their PC on arrival.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (accept),
        .push_data_i (fetch_pc_q),
        .pop_i       (imem_rsp_valid),
        .flush_i     (1'b0),
        .head_o      (rsp_pc),
        .count_o     (pcfifo_count),
        .full_o      (pcfifo_full),
        .empty_o     (pcfifo_empty)
    );

    assign unused_status = ^{ififo_full, pcfifo_count, pcfifo_full, pcfifo_empty, redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural memory with random latency
// and a sequential-PC delivery model that restarts at each redirect target.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int delivered = 0;
    int lat_min = 1;
    int lat_max = 1;
    int rdy_pct = 100;
    int last_due = -1;
    logic [31:0] q_pc[$];
    int          q_due[$];
    logic [31:0] exp_req_pc, exp_inst_pc;

    logic        s_rv, s_acc, s_iv, s_del;
    logic [31:0] s_addr, s_ipc;

    function automatic logic [31:0] memf(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive memory, sample away from the edge, score, advance.
    task automatic tick();
        int due;
        logic rsp;
        rsp = (q_due.size() > 0) && (q_due[0] <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? memf(q_pc[0]) : '0;
        imem_req_ready = (int'($urandom_range(0, 99)) < rdy_pct);
        #1;
        s_rv   = imem_req_valid;
        s_addr = imem_req_addr;
        s_acc  = imem_req_valid && imem_req_ready;
        s_iv   = inst_valid;
        s_ipc  = inst_pc;
        s_del  = inst_valid && inst_ready;
        if (rsp) begin
            void'(q_pc.pop_front());
            void'(q_due.pop_front());
        end
        if (s_acc) begin
            due = cyc + int'($urandom_range(lat_min, lat_max));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            q_pc.push_back(s_addr);
            q_due.push_back(due);
        end
        if (redirect_valid) begin
            checks++;
            if (s_iv !== 1'b0 || s_rv !== 1'b0) begin
                errors++;
                $display("FAIL redirect_gate cyc=%0d inst_valid=%b req_valid=%b exp=0/0", cyc, s_iv, s_rv);
            end
            exp_req_pc  = redirect_pc & 32'hFFFF_FFFC;
            exp_inst_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (s_acc) begin
                checks++;
                if (s_addr !== exp_req_pc) begin
                    errors++;
                    $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, s_addr, exp_req_pc);
                end
                exp_req_pc += 32'd4;
            end
            if (s_del) begin
                checks++;
                if (s_ipc !== exp_inst_pc || inst_data !== memf(exp_inst_pc)) begin
                    errors++;
                    $display("FAIL deliver cyc=%0d got_pc=%h got_data=%h exp_pc=%h exp_data=%h",
                             cyc, s_ipc, inst_data, exp_inst_pc, memf(exp_inst_pc));
                end
                exp_inst_pc += 32'd4;
                delivered++;
            end
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        cyc++;
    endtask

    task automatic assert_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        q_pc.delete();
        q_due.delete();
        last_due = -1;
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        exp_req_pc  = RESET_PC;
        exp_inst_pc = RESET_PC;
        cyc         = 0;
        delivered   = 0;
    endtask

    task automatic test_reset();
        assert_reset();
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs req_valid=%b inst_valid=%b exp=0/0", imem_req_valid, inst_valid);
        end
        release_reset();
    endtask

    task automatic test_sequential();
        lat_min = 1; lat_max = 1; rdy_pct = 100; inst_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) begin
                checks++;
                if (!s_acc || s_addr !== RESET_PC) begin
                    errors++;
                    $display("FAIL first_req acc=%b addr=%h exp=1/%h", s_acc, s_addr, RESET_PC);
                end
            end
            if (i == 1) begin
                checks++;
                if (s_iv !== 1'b0) begin
                    errors++;
                    $display("FAIL no_bypass inst_valid=%b exp=0", s_iv);
                end
            end
            if (i == 2) begin
                checks++;
                if (s_iv !== 1'b1 || s_ipc !== RESET_PC) begin
                    errors++;
                    $display("FAIL first_inst valid=%b pc=%h exp=1/%h", s_iv, s_ipc, RESET_PC);
                end
            end
        end
        checks++;
        if (delivered != 18) begin
            errors++;
            $display("FAIL throughput got=%0d exp=18", delivered);
        end
    endtask

    task automatic test_stall();
        int acc_cnt;
        assert_reset();
        release_reset();
        lat_min = 1; lat_max = 1; rdy_pct = 100; inst_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_acc) acc_cnt++;
        end
        checks++;
        if (acc_cnt != int'(DEPTH) || s_rv !== 1'b0 || s_iv !== 1'b1) begin
            errors++;
            $display("FAIL stall_fill accepts=%0d req_valid=%b inst_valid=%b exp=%0d/0/1", acc_cnt, s_rv, s_iv, DEPTH);
        end
        inst_ready = 1'b1;
        tick();
        checks++;
        if (s_del !== 1'b1 || s_rv !== 1'b0) begin
            errors++;
            $display("FAIL pop_no_credit pop=%b req_valid=%b exp=1/0", s_del, s_rv);
        end
        inst_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (s_acc) acc_cnt++;
        end
        checks++;
        if (acc_cnt != 1) begin
            errors++;
            $display("FAIL refill_one got=%0d exp=1", acc_cnt);
        end
        inst_ready = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_redirect();
        int first_cyc;
        logic [31:0] first_pc;
        assert_reset();
        release_reset();
        lat_min = 3; lat_max = 3; rdy_pct = 100; inst_ready = 1'b1;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick();
        tick();
        checks++;
        if (!s_acc || s_addr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL redirect_req acc=%b addr=%h exp=1/00000100", s_acc, s_addr);
        end
        first_cyc = -1;
        first_pc  = '1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_del && first_cyc < 0) begin
                first_cyc = cyc - 1;
                first_pc  = s_ipc;
            end
        end
        checks++;
        if (first_pc !== 32'h0000_0100 || first_cyc != 8) begin
            errors++;
            $display("FAIL redirect_first pc=%h cyc=%0d exp=00000100/8", first_pc, first_cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tgt2;
        logic [31:0] first_pc;
        logic        seen;
        assert_reset();
        release_reset();
        lat_min = 1; lat_max = 1; rdy_pct = 100; inst_ready = 1'b1;
        repeat (6) tick();
        redirect_valid = 1'b1;
        redirect_pc    = $urandom() | 32'h0000_0003;
        tick();
        tgt2 = $urandom() & 32'hFFFF_FFFC;
        redirect_valid = 1'b1;
        redirect_pc    = tgt2 | 32'h0000_0001;
        tick();
        seen = 1'b0;
        first_pc = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_del && !seen) begin
                seen = 1'b1;
                first_pc = s_ipc;
            end
        end
        checks++;
        if (!seen || first_pc !== tgt2) begin
            errors++;
            $display("FAIL b2b_redirect seen=%b pc=%h exp=1/%h", seen, first_pc, tgt2);
        end
    endtask

    task automatic test_random();
        assert_reset();
        release_reset();
        lat_min = 1; lat_max = 3; rdy_pct = 70;
        for (int i = 0; i < 2000; i++) begin
            inst_ready = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 99) < 4) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom();
            end
            tick();
        end
        checks++;
        if (delivered < 200) begin
            errors++;
            $display("FAIL random_progress got=%0d exp>=200", delivered);
        end
    endtask

    task automatic test_reset_midstream();
        assert_reset();
        release_reset();
        lat_min = 1; lat_max = 1; rdy_pct = 100; inst_ready = 1'b0;
        repeat (10) tick();
        checks++;
        if (s_iv !== 1'b1) begin
            errors++;
            $display("FAIL midreset_fill inst_valid=%b exp=1", s_iv);
        end
        assert_reset();
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear inst_valid=%b req_valid=%b exp=0/0", inst_valid, imem_req_valid);
        end
        release_reset();
        inst_ready = 1'b1;
        tick();
        checks++;
        if (!s_acc || s_addr !== RESET_PC || s_iv !== 1'b0) begin
            errors++;
            $display("FAIL midreset_restart acc=%b addr=%h inst_valid=%b exp=1/%h/0", s_acc, s_addr, s_iv, RESET_PC);
        end
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
